// File: rtl/booth_r4_if.sv
// Controller-to-datapath bus for the radix-4 Booth multiplier.
// The master side drives operands, register enables and mode; the slave side returns flag and product.
interface booth_r4_if #(
  parameter int N = 8
) ();
  logic [N-1:0]   a_in;
  logic [N-1:0]   b_in;
  logic [4:0]     ld;
  logic [4:0]     sel;
  logic           flag;
  logic [2*N-1:0] product;

  modport master (output a_in, b_in, ld, sel, input flag, product);
  modport slave  (input a_in, b_in, ld, sel, output flag, product);
endinterface

// File: rtl/booth_r4_datapath.sv
// Radix-4 modified-Booth multiplier datapath: operand/accumulator registers, one Booth add
// and one 2-bit arithmetic shift per enabled cycle, digit counter and result register.
module booth_r4_datapath #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst,
  booth_r4_if.slave  bus
);
  localparam int CW = $clog2(N/2 + 2);

  logic [N+1:0]   a_r;
  logic [N+1:0]   q_r;
  logic           q_m1;
  logic [N+2:0]   p_r;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] r_r;

  logic           sgn;
  logic [N+1:0]   a_ext;
  logic [N+1:0]   b_ext;
  logic [N+2:0]   a_x;
  logic [N+2:0]   pp;
  logic [N+2:0]   p_sum;
  logic [N+2:0]   p_shf;
  logic [N+1:0]   q_shf;
  logic [2*N-1:0] result;
  logic           sel_unused;

  assign sgn        = bus.sel[0];
  assign sel_unused = ^bus.sel[4:1];

  assign a_ext = sgn ? {{2{bus.a_in[N-1]}}, bus.a_in} : {2'b00, bus.a_in};
  assign b_ext = sgn ? {{2{bus.b_in[N-1]}}, bus.b_in} : {2'b00, bus.b_in};
  assign a_x   = {a_r[N+1], a_r};

  always_comb begin
    pp = '0;
    case ({q_r[1:0], q_m1})
      3'b001, 3'b010: pp = a_x;
      3'b011:         pp = {a_x[N+1:0], 1'b0};
      3'b100:         pp = '0 - {a_x[N+1:0], 1'b0};
      3'b101, 3'b110: pp = '0 - a_x;
      default:        pp = '0;
    endcase
  end

  // Shift always sees the post-add accumulator when add and shift share a cycle.
  assign p_sum = bus.ld[2] ? (p_r + pp) : p_r;
  assign p_shf = {{2{p_sum[N+2]}}, p_sum[N+2:2]};
  assign q_shf = {p_sum[1:0], q_r[N+1:2]};

  // Signed runs N/2 digits, unsigned N/2+1, so the product sits at different offsets.
  assign result = sgn ? {p_r[N-1:0], q_r[N+1:2]} : {p_r[N-3:0], q_r};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r  <= '0;
      q_r  <= '0;
      q_m1 <= 1'b0;
      p_r  <= '0;
      cnt  <= '0;
      r_r  <= '0;
    end else begin
      if (bus.ld[0])
        a_r <= a_ext;
      if (bus.ld[1]) begin
        q_r  <= b_ext;
        q_m1 <= 1'b0;
        p_r  <= '0;
        cnt  <= sgn ? CW'(N/2) : CW'(N/2 + 1);
      end else if (bus.ld[3]) begin
        p_r  <= p_shf;
        q_r  <= q_shf;
        q_m1 <= q_r[1];
        if (cnt != '0)
          cnt <= cnt - 1'b1;
      end else if (bus.ld[2]) begin
        p_r <= p_sum;
      end
      if (bus.ld[4])
        r_r <= result;
    end
  end

  assign bus.flag    = (cnt == '0);
  assign bus.product = r_r;
endmodule

// File: tb/tb_booth_r4_datapath.sv
// Directed self-checking bench for booth_r4_datapath (N=8): vector table of full
// multiplications plus hand-written reset, split-step, priority and abort sequences.
module tb_booth_r4_datapath;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  booth_r4_if #(.N(8)) bus ();

  booth_r4_datapath #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sgn;
    int          digits;
    logic [15:0] prod;
    string       name;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [4:0] l);
    bus.ld = l;
    @(posedge clk);
    #1;
    bus.ld = 5'b0;
  endtask

  // Digit loop flips sel[0] so a datapath that samples the mode live gets caught.
  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input int exp_dig, input logic [15:0] exp_p, input string name);
    int n;
    bus.a_in = a;
    bus.b_in = b;
    bus.sel  = {4'($urandom_range(0, 15)), s};
    cyc(5'b00011);
    n = 0;
    while (bus.flag !== 1'b1 && n < 8) begin
      bus.sel[0] = ~s;
      cyc(5'b01100);
      n++;
    end
    check({name, " digits"}, n, exp_dig);
    bus.sel[0] = s;
    cyc(5'b10000);
    check({name, " product"}, bus.product, exp_p);
  endtask

  initial begin
    int n;
    tests = 0;
    fails = 0;

    vecs[0] = '{8'd7,   8'hFD, 1'b1, 4, 16'hFFEB, "s 7x-3"};
    vecs[1] = '{8'h80,  8'h80, 1'b1, 4, 16'h4000, "s -128x-128"};
    vecs[2] = '{8'h80,  8'h7F, 1'b1, 4, 16'hC080, "s -128x127"};
    vecs[3] = '{8'hFF,  8'hFF, 1'b0, 5, 16'hFE01, "u 255x255"};
    vecs[4] = '{8'd0,   8'd200, 1'b0, 5, 16'h0000, "u 0x200"};
    vecs[5] = '{8'hFF,  8'hFF, 1'b1, 4, 16'h0001, "s -1x-1"};
    vecs[6] = '{8'h7F,  8'h7F, 1'b1, 4, 16'h3F01, "s 127x127"};
    vecs[7] = '{8'd128, 8'd2,  1'b0, 5, 16'h0100, "u 128x2"};
    vecs[8] = '{8'd200, 8'd100, 1'b0, 5, 16'h4E20, "u 200x100"};
    vecs[9] = '{8'h80,  8'h01, 1'b1, 4, 16'hFF80, "s -128x1"};

    bus.a_in = '0;
    bus.b_in = '0;
    bus.ld   = '0;
    bus.sel  = '0;
    rst      = 1'b0;
    #2;
    check("reset product", bus.product, 16'h0000);
    check("reset flag", bus.flag, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++)
      run(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].digits, vecs[i].prod, vecs[i].name);

    // Async reset between edges with a nonzero product held in R.
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async rst product", bus.product, 16'h0000);
    check("async rst flag", bus.flag, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("held rst product", bus.product, 16'h0000);
    check("held rst flag", bus.flag, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    // Split add/shift steps.
    bus.a_in = 8'd6;
    bus.b_in = 8'd5;
    bus.sel  = 5'b00001;
    cyc(5'b00011);
    for (int d = 0; d < 4; d++) begin
      cyc(5'b00100);
      cyc(5'b01000);
    end
    check("split flag", bus.flag, 1'b1);
    cyc(5'b10000);
    check("split product", bus.product, 16'h001E);

    // Shift at cnt==0 must not wrap the counter.
    cyc(5'b01000);
    check("sat flag", bus.flag, 1'b1);

    // Load with shift in the same cycle: load wins, no shift, counter reloads to 4.
    bus.a_in = 8'd7;
    bus.b_in = 8'hFD;
    bus.sel  = 5'b00001;
    cyc(5'b01011);
    n = 0;
    while (bus.flag !== 1'b1 && n < 8) begin
      cyc(5'b01100);
      n++;
    end
    check("ld1+ld3 digits", n, 4);
    cyc(5'b10000);
    check("ld1+ld3 product", bus.product, 16'hFFEB);

    // A reload together with an add uses the old multiplicand.
    bus.a_in = 8'd2;
    bus.b_in = 8'd1;
    cyc(5'b00011);
    bus.a_in = 8'd100;
    cyc(5'b01101);
    for (int d = 0; d < 3; d++)
      cyc(5'b01100);
    check("old A flag", bus.flag, 1'b1);
    cyc(5'b10000);
    check("old A product", bus.product, 16'h0002);

    // Abort after two of four digits.
    bus.a_in = 8'd100;
    bus.b_in = 8'hF9;
    cyc(5'b00011);
    cyc(5'b01100);
    cyc(5'b01100);
    check("pre-abort flag", bus.flag, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("abort flag", bus.flag, 1'b1);
    check("abort product", bus.product, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    cyc(5'b10000);
    check("abort cleared regs", bus.product, 16'h0000);
    run(8'd3, 8'd3, 1'b1, 4, 16'h0009, "s 3x3 after abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
